// File: rtl/nixie_scan_decode_if.sv
// nixie_scan_decode_if
// Bundles the data/control inputs and display outputs of nixie_scan_decode.
//   BCD_IN    : packed BCD word, digit k at [4k+3:4k]
//   LOAD      : capture BCD_IN into the pending buffer
//   ENABLE    : 1 = scan, 0 = dark
//   DIGIT_SEL : one-hot digit strobe
//   ONE_HOT   : one-hot digit value (bit n = value n)
//   FRAME     : one-cycle pulse at start of each frame
//   ERR       : active frame holds a code > 9
// master = producer of BCD/controls (consumer of display lines); slave = the driver.
interface nixie_scan_decode_if #(
  parameter int DIGITS = 6
);
  logic [4*DIGITS-1:0] BCD_IN;
  logic                LOAD;
  logic                ENABLE;
  logic [DIGITS-1:0]   DIGIT_SEL;
  logic [9:0]          ONE_HOT;
  logic                FRAME;
  logic                ERR;

  modport master (
    output BCD_IN, LOAD, ENABLE,
    input  DIGIT_SEL, ONE_HOT, FRAME, ERR
  );

  modport slave (
    input  BCD_IN, LOAD, ENABLE,
    output DIGIT_SEL, ONE_HOT, FRAME, ERR
  );
endinterface

// File: rtl/nixie_scan_decode.sv
// nixie_scan_decode
// Time-multiplexed BCD display driver. Scans DIGITS BCD digits one at a time:
// each slot is BLANK_CYCLES dark clocks followed by DIV lit clocks. New data is
// taken from a pending buffer only at frame start, so a frame never mixes words.
// Optional leading-zero suppression; codes > 9 light nothing and raise ERR.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : nixie_scan_decode_if.slave (BCD_IN, LOAD, ENABLE in;
//           DIGIT_SEL, ONE_HOT, FRAME, ERR out, all registered)
module nixie_scan_decode #(
  parameter int DIGITS       = 6,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  nixie_scan_decode_if.slave     bus
);

  localparam int IW   = $clog2(DIGITS);
  localparam int MAXC = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t              r_state, w_state_n;
  logic [IW-1:0]       r_idx, w_idx_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic                w_frame_start;

  logic [4*DIGITS-1:0] r_pending, w_pending_n;
  logic [4*DIGITS-1:0] r_active, w_active_n;
  logic                r_pend_valid, w_pend_valid_n;

  logic [DIGITS-1:0]   w_supp;
  logic [3:0]          w_digit;
  logic                w_any_bad;

  logic [DIGITS-1:0]   r_digit_sel, w_digit_sel_n;
  logic [9:0]          r_one_hot, w_one_hot_n;
  logic                r_frame;
  logic                r_err, w_err_n;

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_idx_n       = r_idx;
    w_cnt_n       = r_cnt;
    w_frame_start = 1'b0;

    if (!bus.ENABLE) begin
      w_state_n = S_IDLE;
      w_idx_n   = '0;
      w_cnt_n   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_n     = S_BLANK;
          w_idx_n       = '0;
          w_cnt_n       = '0;
          w_frame_start = 1'b1;
        end
        S_BLANK: begin
          if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
            w_state_n = S_SHOW;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == CW'(DIV - 1)) begin
            w_state_n = S_BLANK;
            w_cnt_n   = '0;
            if (r_idx == IW'(DIGITS - 1)) begin
              w_idx_n       = '0;
              w_frame_start = 1'b1;
            end else begin
              w_idx_n = r_idx + 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_idx_n   = '0;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer: LOAD always lands in pending; active swaps only at frame start.
  // A LOAD coinciding with frame start still promotes the old pending word and
  // leaves the new one pending for the next frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pending_n    = r_pending;
    w_pend_valid_n = r_pend_valid;
    w_active_n     = r_active;

    if (w_frame_start && r_pend_valid) begin
      w_active_n     = r_pending;
      w_pend_valid_n = 1'b0;
    end
    if (bus.LOAD) begin
      w_pending_n    = bus.BCD_IN;
      w_pend_valid_n = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit analysis of the word that will be active after this edge:
  // invalid-code OR, leading-zero map (scanned from the top digit down), and
  // selection of the digit about to be shown.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic        v_zero_above;
    int unsigned j;
    w_any_bad    = 1'b0;
    w_supp       = '0;
    w_digit      = '0;
    v_zero_above = 1'b1;
    j            = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      j = DIGITS - 1 - k;
      if (w_active_n[4*j +: 4] > 4'd9) begin
        w_any_bad = 1'b1;
      end
      v_zero_above = v_zero_above && (w_active_n[4*j +: 4] == 4'd0);
      if ((LZ_SUPPRESS != 0) && (j != 0) && v_zero_above) begin
        w_supp[j] = 1'b1;
      end
      if (IW'(j) == w_idx_n) begin
        w_digit = w_active_n[4*j +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, computed from next-state values so the registered outputs
  // change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_digit_sel_n = '0;
    w_one_hot_n   = '0;
    if (w_state_n == S_SHOW) begin
      w_digit_sel_n = DIGITS'(1) << w_idx_n;
      if ((w_digit <= 4'd9) && !w_supp[w_idx_n]) begin
        w_one_hot_n = 10'd1 << w_digit;
      end
    end
  end

  always_comb begin
    w_err_n = r_err;
    if (w_state_n == S_IDLE) begin
      w_err_n = 1'b0;
    end else if (w_frame_start) begin
      w_err_n = w_any_bad;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_pending    <= '0;
      r_active     <= '0;
      r_pend_valid <= 1'b0;
      r_digit_sel  <= '0;
      r_one_hot    <= '0;
      r_frame      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_idx        <= w_idx_n;
      r_cnt        <= w_cnt_n;
      r_pending    <= w_pending_n;
      r_active     <= w_active_n;
      r_pend_valid <= w_pend_valid_n;
      r_digit_sel  <= w_digit_sel_n;
      r_one_hot    <= w_one_hot_n;
      r_frame      <= w_frame_start;
      r_err        <= w_err_n;
    end
  end

  assign bus.DIGIT_SEL = r_digit_sel;
  assign bus.ONE_HOT   = r_one_hot;
  assign bus.FRAME     = r_frame;
  assign bus.ERR       = r_err;

endmodule

// File: tb/tb_nixie_scan_decode.sv
// Bench for nixie_scan_decode: two instances (leading-zero suppression off/on)
// share one stimulus stream; a frame-phase model predicts every output.
module tb_nixie_scan_decode;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BL     = 1;
  localparam int SL     = BL + DIV;
  localparam int FL     = DIGITS * SL;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] s_bcd;
  logic        s_load;
  logic        s_en;

  always #5 CLK = ~CLK;

  nixie_scan_decode_if #(.DIGITS(DIGITS)) if0 ();
  nixie_scan_decode_if #(.DIGITS(DIGITS)) if1 ();

  assign if0.BCD_IN = s_bcd;
  assign if0.LOAD   = s_load;
  assign if0.ENABLE = s_en;
  assign if1.BCD_IN = s_bcd;
  assign if1.LOAD   = s_load;
  assign if1.ENABLE = s_en;

  nixie_scan_decode #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYCLES(BL), .LZ_SUPPRESS(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(if0.slave)
  );
  nixie_scan_decode #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYCLES(BL), .LZ_SUPPRESS(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(if1.slave)
  );

  // Model: whether scanning, cycle position within the frame, and the buffers.
  bit          m_run   = 0;
  int          m_phase = 0;
  logic [15:0] m_pend  = '0;
  logic [15:0] m_act   = '0;
  bit          m_pv    = 0;
  bit          m_err   = 0;
  bit          m_frame = 0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    logic [15:0] t;
    t = w >> (4 * k);
    return t[3:0];
  endfunction

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_pend = '0; m_act = '0; m_pv = 0; m_err = 0; m_frame = 0;
  endtask

  task automatic model_step();
    m_frame = 0;
    if (RESET) begin
      model_reset();
      return;
    end
    if (!s_en) begin
      m_run = 0; m_phase = 0;
    end else if (!m_run) begin
      m_run = 1; m_phase = 0; m_frame = 1;
    end else begin
      m_phase = (m_phase + 1) % FL;
      if (m_phase == 0) m_frame = 1;
    end
    if (m_frame && m_pv) begin
      m_act = m_pend; m_pv = 0;
    end
    if (s_load) begin
      m_pend = s_bcd; m_pv = 1;
    end
    if (!m_run) m_err = 0;
    else if (m_frame) begin
      m_err = 0;
      for (int k = 0; k < DIGITS; k++) if (nib(m_act, k) > 4'd9) m_err = 1;
    end
  endtask

  function automatic bit lit();
    return m_run && ((m_phase % SL) >= BL);
  endfunction

  function automatic logic [3:0] exp_dsel();
    if (!lit()) return 4'd0;
    return 4'(1 << (m_phase / SL));
  endfunction

  function automatic logic [9:0] exp_oh(input bit lz);
    int          slot;
    logic [3:0]  v;
    if (!lit()) return 10'd0;
    slot = m_phase / SL;
    v    = nib(m_act, slot);
    if (v > 4'd9) return 10'd0;
    if (lz && slot != 0 && (m_act >> (4 * slot)) == 16'd0) return 10'd0;
    return 10'(1 << v);
  endfunction

  task automatic compare_all();
    chk("dsel_lz0",  32'(if0.DIGIT_SEL), 32'(exp_dsel()));
    chk("oh_lz0",    32'(if0.ONE_HOT),   32'(exp_oh(0)));
    chk("frame_lz0", 32'(if0.FRAME),     32'(m_frame));
    chk("err_lz0",   32'(if0.ERR),       32'(m_err));
    chk("dsel_lz1",  32'(if1.DIGIT_SEL), 32'(exp_dsel()));
    chk("oh_lz1",    32'(if1.ONE_HOT),   32'(exp_oh(1)));
    chk("frame_lz1", 32'(if1.FRAME),     32'(m_frame));
    chk("err_lz1",   32'(if1.ERR),       32'(m_err));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic load(input logic [15:0] v);
    s_bcd = v; s_load = 1'b1;
    tick();
    s_load = 1'b0;
  endtask

  task automatic run_to_frame();
    bit got;
    got = 0;
    for (int i = 0; i < 4 * FL; i++) begin
      if (!got) begin
        tick();
        if (m_frame) got = 1;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL frame_timeout: got none expected FRAME within %0d cycles", 4 * FL);
    end
  endtask

  initial begin
    RESET = 1'b1; s_bcd = '0; s_load = 1'b0; s_en = 1'b0;
    #12;
    chk("rst_dsel",  32'(if0.DIGIT_SEL), 32'd0);
    chk("rst_oh",    32'(if0.ONE_HOT),   32'd0);
    chk("rst_frame", 32'(if0.FRAME),     32'd0);
    chk("rst_err",   32'(if0.ERR),       32'd0);
    RESET = 1'b0;

    // Basic scan of 1234
    load(16'h1234);
    s_en = 1'b1;
    tick();
    chk("pin_frame0", 32'(if0.FRAME), 32'd1);
    chk("pin_blank0", 32'(if0.DIGIT_SEL), 32'd0);
    tick();
    chk("pin_d0_sel", 32'(if0.DIGIT_SEL), 32'h1);
    chk("pin_d0_oh",  32'(if0.ONE_HOT),   32'h010);
    repeat (18) tick();
    tick();
    chk("pin_frame20", 32'(if0.FRAME), 32'd1);

    // Mid-frame load waits for the boundary
    repeat (7) tick();
    load(16'h5678);
    chk("pin_old_data", 32'(if0.ONE_HOT), 32'h008);
    run_to_frame();
    tick();
    chk("pin_new_data", 32'(if0.ONE_HOT), 32'h100);

    // Last of two loads wins
    load(16'h1111);
    repeat (3) tick();
    load(16'h9087);
    run_to_frame();
    tick();
    chk("pin_last_wins", 32'(if0.ONE_HOT), 32'h080);

    // Invalid code
    load(16'h12F4);
    run_to_frame();
    chk("pin_err_set", 32'(if0.ERR), 32'd1);
    repeat (6) tick();
    chk("pin_bad_sel", 32'(if0.DIGIT_SEL), 32'h2);
    chk("pin_bad_oh",  32'(if0.ONE_HOT),   32'h000);
    load(16'h1234);
    run_to_frame();
    chk("pin_err_clr", 32'(if0.ERR), 32'd0);

    // Leading-zero suppression
    load(16'h0050);
    run_to_frame();
    repeat (6) tick();
    chk("pin_lz_d1_sel", 32'(if1.DIGIT_SEL), 32'h2);
    chk("pin_lz_d1_oh",  32'(if1.ONE_HOT),   32'h020);
    repeat (10) tick();
    chk("pin_lz_d3_sel", 32'(if1.DIGIT_SEL), 32'h8);
    chk("pin_lz_d3_oh",  32'(if1.ONE_HOT),   32'h000);
    chk("pin_nolz_d3",   32'(if0.ONE_HOT),   32'h001);
    load(16'h0000);
    run_to_frame();
    tick();
    chk("pin_lz_zero", 32'(if1.ONE_HOT), 32'h001);
    repeat (FL) tick();

    // Enable drop during digit 2
    load(16'h1234);
    run_to_frame();
    repeat (11) tick();
    chk("pin_d2_sel", 32'(if0.DIGIT_SEL), 32'h4);
    s_en = 1'b0;
    tick();
    chk("pin_dark_sel", 32'(if0.DIGIT_SEL), 32'h0);
    chk("pin_dark_oh",  32'(if0.ONE_HOT),   32'h0);
    repeat (3) tick();
    s_en = 1'b1;
    tick();
    chk("pin_reen_frame", 32'(if0.FRAME), 32'd1);
    tick();
    chk("pin_reen_sel", 32'(if0.DIGIT_SEL), 32'h1);
    chk("pin_reen_oh",  32'(if0.ONE_HOT),   32'h010);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      int          z;
      w = 16'($urandom);
      z = $urandom_range(0, 4);
      for (int k = 0; k < DIGITS; k++) if (k >= DIGITS - z) w = w & ~(16'hF << (4 * k));
      s_bcd  = w;
      s_load = ($urandom_range(0, 9) == 0);
      if (s_en && $urandom_range(0, 99) == 0) s_en = 1'b0;
      else if (!s_en && $urandom_range(0, 4) == 0) s_en = 1'b1;
      tick();
    end
    s_load = 1'b0;
    s_en   = 1'b1;

    // Asynchronous reset while a digit is lit
    for (int i = 0; i < 2 * FL; i++) if (!lit()) tick();
    #2;
    RESET = 1'b1;
    #1;
    chk("pin_arst_sel",   32'(if0.DIGIT_SEL), 32'd0);
    chk("pin_arst_oh",    32'(if0.ONE_HOT),   32'd0);
    chk("pin_arst_frame", 32'(if0.FRAME),     32'd0);
    chk("pin_arst_err",   32'(if0.ERR),       32'd0);
    model_reset();
    tick();
    RESET = 1'b0;
    tick();
    chk("pin_post_frame", 32'(if0.FRAME), 32'd1);
    tick();
    chk("pin_post_sel",    32'(if0.DIGIT_SEL), 32'h1);
    chk("pin_post_oh_lz0", 32'(if0.ONE_HOT),   32'h001);
    chk("pin_post_oh_lz1", 32'(if1.ONE_HOT),   32'h001);
    repeat (FL + 5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nixie_scan_decode.md
Name: nixie_scan_decode

Overview:
Time-multiplexed BCD display driver for the watch datapath; parametrised successor to the single-digit binary-to-one-hot decoder. Holds a DIGITS-wide BCD word and scans it one digit at a time. For each scan slot it drives a one-hot digit strobe and a registered 10-line one-hot value (tube cathode / segment-group select). Adds an anti-ghosting blank gap, frame-synchronous update, leading-zero suppression and invalid-code flagging.

Parameters:
DIGITS, 6, number of BCD digits scanned (2..8); digit 0 is least significant.
DIV, 1000, clocks each digit is lit per slot (>=1).
BLANK_CYCLES, 2, clocks of all-off gap before each lit slot (>=1).
LZ_SUPPRESS, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
BCD_IN  input  4*DIGITS  packed BCD; digit k at bits [4k+3:4k]
LOAD  input  1  capture BCD_IN into pending register this cycle
ENABLE  input  1  1 = scan; 0 = display dark
DIGIT_SEL  output  DIGITS  one-hot digit strobe; all-zero when dark or blanking
ONE_HOT  output  10  one-hot digit value; bit n = value n; all-zero when dark, blanking, suppressed or invalid
FRAME  output  1  one-cycle pulse at start of each frame
ERR  output  1  1 while active frame contains any code > 9

Behaviour:
- Reset (async, immediate): state IDLE; pending, active buffers = 0; pend_valid = 0; idx = 0; slot counter = 0; DIGIT_SEL, ONE_HOT, FRAME, ERR = 0.
- All outputs registered; they change on the same edge as the state.
- LOAD=1: pending <= BCD_IN, pend_valid <= 1. Later LOAD before the frame boundary overwrites pending (last wins).
- States: IDLE, BLANK, SHOW.
- IDLE: outputs dark. If ENABLE=1, next edge -> BLANK, idx = 0, frame-start actions apply.
- Frame-start actions, on entering BLANK with idx 0 (from IDLE or wrap):
  - If pend_valid: active <= pending, pend_valid <= 0. A LOAD on this same edge wins: it goes to pending and pend_valid stays 1.
  - FRAME = 1 for exactly that cycle.
  - ERR <= OR over digits of (new active digit > 9).
- BLANK: DIGIT_SEL = 0, ONE_HOT = 0; lasts exactly BLANK_CYCLES clocks, then -> SHOW.
- SHOW: DIGIT_SEL = 1<<idx; ONE_HOT = decode(active[idx]); lasts exactly DIV clocks.
  - Then idx <= (idx == DIGITS-1) ? 0 : idx+1, and -> BLANK.
- Frame length: DIGITS*(BLANK_CYCLES+DIV) clocks; FRAME period is the same.
- Decode: value v in 0..9 -> ONE_HOT = 1<<v. Value 10..15 -> ONE_HOT = 0 (digit dark, DIGIT_SEL still strobes).
- Leading-zero suppression (LZ_SUPPRESS=1): digit k is suppressed when it is 0 and all digits above k are 0, for k >= 1. Suppressed digit: ONE_HOT = 0, DIGIT_SEL still strobes. Digit 0 is never suppressed, so all-zero shows a single "0".
- ENABLE falls in any state: next edge -> IDLE, outputs dark; idx and slot counter cleared. Pending and active buffers are kept. Re-enable restarts at frame start.
- At most one DIGIT_SEL bit is high on any cycle, and DIGIT_SEL is never high in the cycle adjacent to a different digit's strobe.
- RESET mid-slot: outputs go dark immediately, independent of CLK.

Test Plan:
- DIGITS=4, DIV=4, BLANK_CYCLES=1, LZ=0: load 16'h1234, ENABLE=1 -> FRAME pulse. Per digit: 1 dark clock, then 4 lit clocks. Sequence is DIGIT_SEL 0001/ONE_HOT bit4, 0010/bit3, 0100/bit2, 1000/bit1. FRAME repeats every 20 clocks.
- LOAD 16'h5678 mid-frame -> current frame still shows 1234. The next frame after the FRAME pulse shows 5678. Two LOADs in one frame -> only the last appears.
- Load 16'h12F4 -> ERR=1 from the next frame start. Digit 1 strobes with ONE_HOT=0. Loading 16'h1234 clears ERR at the following frame start.
- LZ=1, load 16'h0050 -> digits 3 and 2 dark, digit 1 shows bit5, digit 0 shows bit0. Load 16'h0000 -> only digit 0 lit, showing bit0.
- Drop ENABLE during SHOW of digit 2 -> dark next clock. Re-assert -> FRAME, restart at digit 0 with the same data.
- Assert RESET asynchronously mid-SHOW -> outputs 0 before the next edge. After release with ENABLE=1, scan starts with active = 0.
